mvau_weight_loader: RTL
=======================

# mvau_weight_loader

Runtime weight loader for the MVAU: accepts a stream of SIMD×TW-bit weight words over an AXI-Stream slave and writes them sequentially into the write port of a PE's weight memory. It is the write-side counterpart of the MVAU's per-PE read-only weight memory, so weights can be reloaded without re-synthesis. One instance sits between the weight DMA/stream and each PE's dual-port weight RAM.

## Interface
- SIMD, 2, number of weights per memory word
- TW, 1, bits per weight
- WMEM_DEPTH, 4, words per PE memory, (KDim²·IFMCh·OFMCh)/(SIMD·PE)
- WMEM_ADDR_BW, 4, address width; requires 2^WMEM_ADDR_BW ≥ WMEM_DEPTH
- Clocking: one clock, `aclk`; reset `aresetn` is asynchronous and active-low.
- aclk  in  1  main clock
- aresetn  in  1  asynchronous active-low reset
- load_start  in  1  single-cycle pulse; begins a load from address 0
- in_wgt_tdata  in  SIMD*TW  weight word
- in_wgt_tvalid  in  1  stream valid
- in_wgt_tlast  in  1  marks final word of a load
- in_wgt_tready  out  1  stream ready
- wmem_we  out  1  memory write enable
- wmem_waddr  out  WMEM_ADDR_BW  memory write address
- wmem_wdata  out  SIMD*TW  memory write data
- busy  out  1  high while in LOAD
- load_done  out  1  one-cycle pulse on completion
- len_err  out  1  sticky tlast/length mismatch flag

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: in_wgt_tready=0. load_start=1 → LOAD; beat counter cleared to 0; len_err cleared.
- LOAD: in_wgt_tready=1, busy=1. Handshake = tvalid & tready. Each handshake registers tdata and the current counter value, then increments the counter.
- Handshake with counter = WMEM_DEPTH-1 → DONE (no wrap; counter never exceeds WMEM_DEPTH-1).
- len_err set if tlast=1 on a handshake with counter < WMEM_DEPTH-1, or tlast=0 on the final handshake. The load still runs to exactly WMEM_DEPTH beats; early tlast does not terminate it.
- DONE: lasts one cycle; load_done=1, tready=0, then → IDLE.
- load_start while in LOAD or DONE is ignored.
- Data is written verbatim; no width conversion. SIMD lane 0 occupies bits [TW-1:0].

## Timing
- Reset values: in_wgt_tready=0, wmem_we=0, wmem_waddr=0, wmem_wdata=0, busy=0, load_done=0, len_err=0; state=IDLE; counter=0.
- in_wgt_tready is a function of registered state only (no combinational path from tvalid).
- Write latency is 1 cycle: a handshake at edge k produces wmem_we=1 with the matching addr/data for the cycle after edge k. Back-to-back handshakes give back-to-back writes.
- Throughput is 1 word/cycle while in LOAD.
- The final handshake at cycle N gives, in cycle N+1: wmem_we=1, waddr=WMEM_DEPTH-1, state=DONE, load_done=1, tready=0. In cycle N+2 the block is IDLE and another load_start is accepted.
- wmem_waddr and wmem_wdata hold their last values when wmem_we=0.
- Reset mid-load: all outputs return to reset values immediately (asynchronous). Words already written remain in memory. load_done is not pulsed.
- WMEM_DEPTH=1: a single handshake goes LOAD→DONE; that beat's tlast must be 1.

## Structure
- Package `mvau_weight_pkg`: FSM state enum (IDLE/LOAD/DONE) and a `wmem_word_t` helper width function of SIMD·TW.
- Sub-module `mvau_weight_mem_rw`: simple dual-port RAM with a synchronous write port driven by this block and a registered read port with the same read timing as the existing weight memory. It is instantiated in the PE wrapper, not inside the loader.

## Test plan
- Reset then idle: with tvalid=1 and no load_start, in_wgt_tready stays 0 and wmem_we stays 0 for 20 cycles.
- Nominal: WMEM_DEPTH=4; load_start, then 4 back-to-back beats 0xA,0xB,0xC,0xD with tlast on the 4th → writes at addr 0..3 with those data on consecutive cycles; load_done pulses with the addr-3 write; len_err=0; readback through mvau_weight_mem_rw matches.
- Backpressure/gaps: tvalid toggles 1,0,0,1,1,0,1 → exactly 4 writes, addresses contiguous 0..3, no write in gap cycles.
- Length errors: tlast on beat 2 of 4 → len_err=1, load still completes 4 writes. Separately, no tlast on beat 4 → len_err=1. Next load_start clears len_err.
- Reset mid-load: aresetn low after 2 of 4 beats → outputs at reset values immediately, no load_done. A fresh load afterwards writes from addr 0.
- Ignored restart: load_start pulsed during LOAD at beat 1 → counter unaffected, addresses continue 2,3.

Source files
------------

// File: rtl/mvau_weight_pkg.sv
// mvau_weight_pkg
//   Shared definitions for the MVAU runtime weight loader and the PE weight
//   memory write port.
//   - state_t          : loader FSM states (IDLE / LOAD / DONE)
//   - wmem_word_width  : width of one weight-memory word (SIMD lanes of TW bits)
package mvau_weight_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One memory word packs SIMD weights of TW bits each; lane 0 sits in the LSBs.
  function automatic int wmem_word_width(input int simd, input int tw);
    return simd * tw;
  endfunction

endpackage

// File: rtl/mvau_weight_mem_rw.sv
// mvau_weight_mem_rw
//   Simple dual-port weight RAM for one PE. The write port is fed by
//   mvau_weight_loader; the read port has the same one-cycle registered read
//   latency as the read-only weight memory it replaces.
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  read data, valid the cycle after raddr is presented
//   Instantiated in the PE wrapper, beside the loader rather than inside it.
module mvau_weight_mem_rw #(
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 4,
  parameter int ADDR_BW = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_BW-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [ADDR_BW-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  // Storage covers the full address space so every address is a legal index;
  // only the first DEPTH words are ever written.
  logic [WIDTH-1:0] mem [2**ADDR_BW];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
    // Read-before-write on a same-address collision: old data is returned.
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mvau_weight_loader.sv
// mvau_weight_loader
//   Accepts a stream of SIMD*TW-bit weight words and writes them, in order,
//   to addresses 0 .. WMEM_DEPTH-1 of a PE weight memory write port.
//   Ports:
//     aclk           in   clock
//     aresetn        in   asynchronous active-low reset
//     load_start     in   one-cycle pulse, starts a load at address 0 (IDLE only)
//     in_wgt_tdata   in   weight word
//     in_wgt_tvalid  in   stream valid
//     in_wgt_tlast   in   final word of a load
//     in_wgt_tready  out  stream ready (high exactly while in LOAD)
//     wmem_we        out  memory write enable (one cycle after each handshake)
//     wmem_waddr     out  memory write address (holds when wmem_we=0)
//     wmem_wdata     out  memory write data (holds when wmem_we=0)
//     busy           out  high while in LOAD
//     load_done      out  one-cycle pulse in DONE, coincides with the last write
//     len_err        out  sticky tlast/length mismatch, cleared by load_start
//     state_dbg      out  current FSM state (state_t encoding)
//
//   Stream handshake: a word transfers on a rising edge where
//   in_wgt_tvalid=1 and in_wgt_tready=1. tready depends only on the
//   registered state, so there is no combinational path from tvalid.
module mvau_weight_loader
  import mvau_weight_pkg::*;
#(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic                                  load_start,
  input  logic [wmem_word_width(SIMD, TW)-1:0]  in_wgt_tdata,
  input  logic                                  in_wgt_tvalid,
  input  logic                                  in_wgt_tlast,
  output logic                                  in_wgt_tready,
  output logic                                  wmem_we,
  output logic [WMEM_ADDR_BW-1:0]               wmem_waddr,
  output logic [wmem_word_width(SIMD, TW)-1:0]  wmem_wdata,
  output logic                                  busy,
  output logic                                  load_done,
  output logic                                  len_err,
  output logic [1:0]                            state_dbg
);

  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  state_t                  state;
  logic [WMEM_ADDR_BW-1:0] cnt;
  logic                    hs;
  logic                    at_last;

  assign in_wgt_tready = (state == ST_LOAD);
  assign busy          = (state == ST_LOAD);
  assign state_dbg     = state;
  assign hs            = in_wgt_tvalid & in_wgt_tready;
  assign at_last       = (cnt == LAST_ADDR);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wmem_we    <= 1'b0;
      wmem_waddr <= '0;
      wmem_wdata <= '0;
      load_done  <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      wmem_we   <= 1'b0;
      load_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state   <= ST_LOAD;
            cnt     <= '0;
            len_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          // load_start is deliberately not looked at here: a restart request
          // mid-load must not disturb the address sequence.
          if (hs) begin
            wmem_we    <= 1'b1;
            wmem_waddr <= cnt;
            wmem_wdata <= in_wgt_tdata;
            if (at_last) begin
              // Counter stays at the last address; it is cleared on the next start.
              state     <= ST_DONE;
              load_done <= 1'b1;
              if (!in_wgt_tlast) len_err <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
              // An early tlast is only flagged; the load still runs to full length.
              if (in_wgt_tlast) len_err <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
